// File: rtl/interboard_tx_arbiter.sv
// interboard_tx_arbiter: two-requester message arbiter in front of the
// inter-board link. Each requester has a 2-entry FIFO; one message at a time
// is handed to the link transmitter (IDLE -> ISSUE -> WAIT_READY).
// Optional feature macro: TX_TIMEOUT_EN (WAIT_READY timeout with retries).
module interboard_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interboard_rst,
  input  logic       req0_en,
  input  logic [2:0] req0_msg_type,
  input  logic [4:0] req0_number,
  input  logic       req1_en,
  input  logic [2:0] req1_msg_type,
  input  logic [4:0] req1_number,
  input  logic       inter_ready,
  output logic       ctrl_en,
  output logic [2:0] ctrl_msg_type,
  output logic [4:0] ctrl_number,
  output logic       transmit,
  output logic       req0_full,
  output logic       req1_full,
  output logic       req0_done,
  output logic       req1_done,
  output logic [1:0] overflow,
  output logic       tx_error
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_READY} state_t;

  state_t     state_reg, state_next;
  logic       any_rst;
  logic [1:0] push_en;
  logic [7:0] push_data [2];
  logic [1:0] fifo_empty;
  logic [1:0] fifo_full;
  logic [1:0] fifo_drop;
  logic [1:0] pop_en;
  logic [7:0] fifo_head [2];
  logic       grant_valid;
  logic       grant_idx;
  logic       load_grant;
  logic       issue_now;
  logic       done_now;
  logic       last_grant_reg;
  logic       owner_reg;
  logic [2:0] ctrl_type_reg;
  logic [4:0] ctrl_num_reg;
`ifdef TX_TIMEOUT_EN
  logic       timeout_hit;
  logic       retry_ok;
  logic       retry_now;
  logic       abandon_now;
  logic [15:0] timeout_cnt_reg;
  logic [2:0]  retry_cnt_reg;
`endif

  // Either reset source has identical effect.
  assign any_rst = rst | interboard_rst;

  assign push_en      = {req1_en, req0_en};
  assign push_data[0] = {req0_msg_type, req0_number};
  assign push_data[1] = {req1_msg_type, req1_number};

  // One 2-entry FIFO per requester; a push into a full FIFO is still taken
  // when that FIFO is being popped in the same cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [7:0] mem_reg [2];
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       push_ok;

    assign fifo_empty[gi] = (count_reg == 2'd0);
    assign fifo_full[gi]  = (count_reg == 2'd2);
    assign fifo_head[gi]  = mem_reg[rd_ptr_reg];
    assign push_ok        = push_en[gi] & (~fifo_full[gi] | pop_en[gi]);
    assign fifo_drop[gi]  = push_en[gi] & ~push_ok;

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
      if (any_rst) begin
        wr_ptr_reg <= 1'b0;
        rd_ptr_reg <= 1'b0;
        count_reg  <= 2'd0;
      end else begin
        if (push_ok) begin
          mem_reg[wr_ptr_reg] <= push_data[gi];
          wr_ptr_reg          <= ~wr_ptr_reg;
        end
        if (pop_en[gi]) begin
          rd_ptr_reg <= ~rd_ptr_reg;
        end
        count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop_en[gi]};
      end
    end
  end

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    grant_valid = ~(fifo_empty[0] & fifo_empty[1]);
    if (!fifo_empty[0] && !fifo_empty[1]) begin
      grant_idx = ~last_grant_reg;
    end else begin
      grant_idx = fifo_empty[0];
    end
  end

`ifdef TX_TIMEOUT_EN
  assign timeout_hit = (state_reg == WAIT_READY) &&
                       (timeout_cnt_reg == 16'(TIMEOUT_CYCLES - 1));
  assign retry_ok    = (retry_cnt_reg < 3'(MAX_RETRY));
`endif

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next = state_reg;
    pop_en     = 2'b00;
    load_grant = 1'b0;
    issue_now  = 1'b0;
    done_now   = 1'b0;
`ifdef TX_TIMEOUT_EN
    retry_now   = 1'b0;
    abandon_now = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          load_grant        = 1'b1;
          pop_en[grant_idx] = 1'b1;
          state_next        = ISSUE;
        end
      end
      ISSUE: begin
        issue_now  = 1'b1;
        state_next = WAIT_READY;
      end
      WAIT_READY: begin
        if (inter_ready) begin
          done_now   = 1'b1;
          state_next = IDLE;
        end
`ifdef TX_TIMEOUT_EN
        else if (timeout_hit) begin
          if (retry_ok) begin
            retry_now  = 1'b1;
            state_next = ISSUE;
          end else begin
            abandon_now = 1'b1;
            state_next  = IDLE;
          end
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // State, round-robin history and the held message presented to the link.
  always_ff @(posedge clk) begin
    if (any_rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      ctrl_type_reg  <= 3'd0;
      ctrl_num_reg   <= 5'd0;
    end else begin
      state_reg <= state_next;
      if (load_grant) begin
        last_grant_reg                <= grant_idx;
        owner_reg                     <= grant_idx;
        {ctrl_type_reg, ctrl_num_reg} <= fifo_head[grant_idx];
      end
    end
  end

`ifdef TX_TIMEOUT_EN
  // Cycles spent in WAIT_READY and retries used for the current message.
  always_ff @(posedge clk) begin
    if (any_rst) begin
      timeout_cnt_reg <= 16'd0;
      retry_cnt_reg   <= 3'd0;
    end else begin
      if (state_reg == WAIT_READY && state_next == WAIT_READY) begin
        timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
      end else begin
        timeout_cnt_reg <= 16'd0;
      end
      if (load_grant) begin
        retry_cnt_reg <= 3'd0;
      end else if (retry_now) begin
        retry_cnt_reg <= retry_cnt_reg + 3'd1;
      end
    end
  end

  assign tx_error = ~any_rst & abandon_now;
`else
  assign tx_error = 1'b0;
`endif

  // Outputs are forced low while either reset is held.
  assign ctrl_en       = ~any_rst & issue_now;
  assign transmit      = ~any_rst & (state_reg != IDLE);
  assign ctrl_msg_type = any_rst ? 3'd0 : ctrl_type_reg;
  assign ctrl_number   = any_rst ? 5'd0 : ctrl_num_reg;
  assign req0_full     = ~any_rst & fifo_full[0];
  assign req1_full     = ~any_rst & fifo_full[1];
  assign req0_done     = ~any_rst & done_now & ~owner_reg;
  assign req1_done     = ~any_rst & done_now & owner_reg;
  assign overflow      = any_rst ? 2'b00 : fifo_drop;

endmodule

// File: doc/interboard_tx_arbiter.md
INTERBOARD_TX_ARBITER -- requirements
Module: interboard_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, cycles waited in WAIT_READY before retry (valid range 2..65535).
REQ-002 SHALL have parameter MAX_RETRY, default 3, retries after the first issue before abandoning (valid range 0..7).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 interboard_rst  in  1  synchronous, active-high reset from peer board; same effect as rst.
REQ-006 req0_en  in  1  one-cycle push request from game FSM.
REQ-007 req0_msg_type  in  3  message type for req0 push.
REQ-008 req0_number  in  5  number payload for req0 push.
REQ-009 req1_en  in  1  one-cycle push request from secondary source (restart/control).
REQ-010 req1_msg_type  in  3  message type for req1 push.
REQ-011 req1_number  in  5  number payload for req1 push.
REQ-012 inter_ready  in  1  link pulse: current message delivered.
REQ-013 ctrl_en  out  1  one-cycle strobe to link transmitter.
REQ-014 ctrl_msg_type  out  3  registered message type presented with ctrl_en.
REQ-015 ctrl_number  out  5  registered number presented with ctrl_en.
REQ-016 transmit  out  1  high while a message is owned by the link (ISSUE or WAIT_READY).
REQ-017 req0_full, req1_full  out  1 each  queue holds 2 entries.
REQ-018 req0_done, req1_done  out  1 each  one-cycle pulse on delivery of that requester's message.
REQ-019 overflow  out  2  bit N pulses when a reqN push is dropped.
REQ-020 tx_error  out  1  one-cycle pulse when a message is abandoned.

Function
REQ-021 Each requester SHALL own a 2-entry FIFO of {msg_type, number}; push on reqN_en when not full.
REQ-022 Push while full SHALL be dropped and pulse overflow[N], unless that FIFO pops in the same cycle, in which case the push is accepted.
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT_READY.
REQ-024 IDLE: if any FIFO non-empty, grant one, pop its head into ctrl_msg_type/ctrl_number, go ISSUE; else stay.
REQ-025 Grant SHALL be round-robin: when both non-empty, grant the requester not granted last; last_grant resets to 1 (req0 wins first tie).
REQ-026 ISSUE: ctrl_en=1 for exactly one cycle, then go WAIT_READY; inter_ready sampled in ISSUE is ignored.
REQ-027 WAIT_READY: on inter_ready, pulse reqN_done for the granted requester, go IDLE.
REQ-028 Latency: push into empty FIFO in IDLE at cycle t -> ctrl_en at t+2; back-to-back messages SHALL be separated by at least one IDLE cycle.
REQ-029 transmit SHALL be 1 in ISSUE and WAIT_READY, 0 in IDLE.
REQ-030 ctrl_msg_type/ctrl_number SHALL hold their value from grant until the next grant.
REQ-031 Pushes SHALL be accepted in every state, including during ISSUE/WAIT_READY.

Reset
REQ-032 rst or interboard_rst SHALL, on the next edge: state IDLE, FIFOs empty, last_grant=1, retry and timeout counters 0, ctrl_msg_type=0, ctrl_number=0.
REQ-033 While reset is asserted, all outputs SHALL be 0 and pushes SHALL be ignored.
REQ-034 Reset mid-WAIT_READY SHALL abandon the message with no done or tx_error pulse.

Configuration
REQ-035 Macro TX_TIMEOUT_EN defined: WAIT_READY counts cycles; at TIMEOUT_CYCLES without inter_ready, if retries < MAX_RETRY, increment retries and return to ISSUE with the same data; else pulse tx_error and go IDLE. Retries clear on every grant.
REQ-036 TX_TIMEOUT_EN undefined: no counters synthesized, WAIT_READY waits indefinitely, tx_error tied 0.

Verification
REQ-037 req0 push {3'd1, 5'd17} in IDLE at cycle 0 -> ctrl_en at cycle 2 with type 1 / number 17, transmit 1 from cycle 2; inter_ready at cycle 5 -> req0_done at cycle 5, IDLE at cycle 6.
REQ-038 req0 and req1 push in the same cycle, twice each -> grant order req0, req1, req0, req1.
REQ-039 Three req1 pushes while busy with no pop -> req1_full after 2; third push drops, overflow=2'b10.
REQ-040 TX_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, MAX_RETRY=1, no inter_ready -> ctrl_en twice, then tx_error, then IDLE.
REQ-041 interboard_rst asserted in WAIT_READY with one entry queued in each FIFO -> IDLE, both FIFOs empty, no done pulse, no ctrl_en afterwards.
